// File: rtl/dense_lanes.sv
// dense_lanes: fully-connected layer with LANES neurons evaluated in parallel.
//   out[o] = act(bias[o] + sum_i((in[i] * w[o][i]) >>> FRAC_BITS))
// Weights and biases are written at runtime and can only be changed while the
// block is idle (LOAD). Results are saturated to FEATURE_W bits, with an
// optional ReLU.
//
// Ports:
//   clock, reset_n            clock (rising edge), async active-high reset
//   in_valid/in_ready/in_data    input feature stream, one feature per beat
//   out_valid/out_ready/out_data output feature stream, o = 0..OUT_LEN-1
//   relu_en                   clamp negative results to zero (sampled in FINAL)
//   wgt_we/wgt_addr/wgt_data  weight write port, addr = o*IN_LEN + i
//   bias_we/bias_addr/bias_data bias write port
//   busy                      high whenever the block is not in LOAD
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | accept IN_LEN input features into the input buffer
// COMPUTE | IN_LEN MAC cycles for the current group of LANES outputs
// FINAL   | add bias, saturate, ReLU, capture results into output bank
// EMIT    | present LANES results one by one on the output stream
module dense_lanes #(
    parameter int IN_LEN    = 784,
    parameter int OUT_LEN   = 100,
    parameter int LANES     = 4,
    parameter int FEATURE_W = 16,
    parameter int WEIGHT_W  = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [FEATURE_W-1:0]          in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [FEATURE_W-1:0]          out_data,
    input  logic                                 relu_en,
    input  logic                                 wgt_we,
    input  logic [$clog2(IN_LEN*OUT_LEN)-1:0]    wgt_addr,
    input  logic signed [WEIGHT_W-1:0]           wgt_data,
    input  logic                                 bias_we,
    input  logic [$clog2(OUT_LEN)-1:0]           bias_addr,
    input  logic signed [WEIGHT_W-1:0]           bias_data,
    output logic                                 busy
);

    localparam int NG    = OUT_LEN / LANES;
    localparam int AW    = $clog2(IN_LEN * OUT_LEN);
    localparam int BW    = $clog2(OUT_LEN);
    localparam int IDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
    localparam int G_W   = (NG > 1) ? $clog2(NG) : 1;
    localparam int LN_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW    = FEATURE_W + WEIGHT_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (FEATURE_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (FEATURE_W - 1));

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IN_LEN - 1);
    localparam logic [G_W-1:0]   G_LAST    = G_W'(NG - 1);
    localparam logic [LN_W-1:0]  LANE_LAST = LN_W'(LANES - 1);

    if (OUT_LEN % LANES != 0) begin : g_bad_cfg
        $error("dense_lanes: OUT_LEN must be a multiple of LANES");
    end

    typedef enum logic [1:0] {LOAD, COMPUTE, FINAL, EMIT} state_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [G_W-1:0]   g_q;
    logic [LN_W-1:0]  lane_q;

    logic signed [FEATURE_W-1:0] in_buf   [IN_LEN];
    logic signed [WEIGHT_W-1:0]  wgt_mem  [IN_LEN*OUT_LEN];
    logic signed [WEIGHT_W-1:0]  bias_mem [OUT_LEN];
    logic signed [ACC_W-1:0]     acc      [LANES];
    logic signed [ACC_W-1:0]     term     [LANES];
    logic signed [FEATURE_W-1:0] lane_res [LANES];
    logic signed [FEATURE_W-1:0] bank     [LANES];

    logic in_hs, out_hs;

    // in_ready is held low for as long as reset is asserted.
    assign in_ready  = (state_q == LOAD) && !reset_n;
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != LOAD);
    assign out_data  = out_valid ? bank[lane_q] : '0;
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_hs && idx_q == IDX_LAST) state_d = COMPUTE;
            COMPUTE: if (idx_q == IDX_LAST) state_d = FINAL;
            FINAL:   state_d = EMIT;
            EMIT: begin
                if (out_hs && lane_q == LANE_LAST)
                    state_d = (g_q == G_LAST) ? LOAD : COMPUTE;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q <= LOAD;
            idx_q   <= '0;
            g_q     <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        if (idx_q == IDX_LAST) begin
                            idx_q <= '0;
                            g_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                COMPUTE: idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                FINAL:   lane_q <= '0;
                EMIT: begin
                    if (out_hs) begin
                        if (lane_q == LANE_LAST) begin
                            lane_q <= '0;
                            idx_q  <= '0;
                            g_q    <= (g_q == G_LAST) ? '0 : g_q + 1'b1;
                        end else begin
                            lane_q <= lane_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately left out of reset so that loaded weights and
    // biases survive a mid-operation reset.
    always_ff @(posedge clock) begin
        if (in_hs)
            in_buf[idx_q] <= in_data;
        if (wgt_we && !busy)
            wgt_mem[wgt_addr] <= wgt_data;
        if (bias_we && !busy)
            bias_mem[bias_addr] <= bias_data;
        for (int l = 0; l < LANES; l++) begin
            if (state_q != COMPUTE && state_d == COMPUTE)
                acc[l] <= '0;
            else if (state_q == COMPUTE)
                acc[l] <= acc[l] + term[l];
            if (state_q == FINAL)
                bank[l] <= lane_res[l];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [AW-1:0]           w_idx;
        logic [BW-1:0]           b_idx;
        logic signed [PW-1:0]    prod;
        logic signed [PW-1:0]    prod_sh;
        logic signed [ACC_W-1:0] sum;
        logic signed [FEATURE_W-1:0] sat;

        assign w_idx   = AW'((g_q * LANES + l) * IN_LEN + idx_q);
        assign b_idx   = BW'(g_q * LANES + l);
        assign prod    = PW'(in_buf[idx_q]) * PW'(wgt_mem[w_idx]);
        assign prod_sh = prod >>> FRAC_BITS;
        assign term[l] = ACC_W'(prod_sh);
        // Bias is already at feature scale, so it is added without shifting.
        assign sum     = acc[l] + ACC_W'(bias_mem[b_idx]);

        always_comb begin
            if (sum > SAT_MAX)
                sat = SAT_MAX[FEATURE_W-1:0];
            else if (sum < SAT_MIN)
                sat = SAT_MIN[FEATURE_W-1:0];
            else
                sat = sum[FEATURE_W-1:0];
            lane_res[l] = (relu_en && sat[FEATURE_W-1]) ? '0 : sat;
        end
    end

endmodule

// File: tb/tb_dense_lanes.sv
// Directed testbench for dense_lanes with a 4-input, 4-output, 2-lane config.
module tb_dense_lanes;

    localparam int IN_LEN = 4, OUT_LEN = 4, LANES = 2;
    localparam int FW = 16, WW = 16, FRAC = 8, ACC_W = 40;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                 reset_n;
    logic                 in_valid, in_ready;
    logic signed [FW-1:0] in_data;
    logic                 out_valid, out_ready;
    logic signed [FW-1:0] out_data;
    logic                 relu_en;
    logic                 wgt_we;
    logic [3:0]           wgt_addr;
    logic signed [WW-1:0] wgt_data;
    logic                 bias_we;
    logic [1:0]           bias_addr;
    logic signed [WW-1:0] bias_data;
    logic                 busy;

    dense_lanes #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .LANES(LANES), .FEATURE_W(FW),
        .WEIGHT_W(WW), .FRAC_BITS(FRAC), .ACC_W(ACC_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .relu_en(relu_en),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .busy(busy)
    );

    int checks = 0;
    int fails  = 0;
    logic signed [FW-1:0] in_vec [IN_LEN];
    logic signed [FW-1:0] res    [OUT_LEN];
    int lat;

    task automatic set_cfg(input logic signed [WW-1:0] wv,
                           input logic signed [WW-1:0] b0, b1, b2, b3);
        logic signed [WW-1:0] bv [4];
        bv[0] = b0; bv[1] = b1; bv[2] = b2; bv[3] = b3;
        for (int a = 0; a < IN_LEN * OUT_LEN; a++) begin
            wgt_we    = 1'b1;
            wgt_addr  = 4'(a);
            wgt_data  = wv;
            bias_we   = (a < OUT_LEN);
            bias_addr = 2'(a);
            bias_data = bv[a % 4];
            @(posedge clock); #1;
        end
        wgt_we  = 1'b0;
        bias_we = 1'b0;
    endtask

    task automatic set_vec(input logic signed [FW-1:0] v0, v1, v2, v3);
        in_vec[0] = v0; in_vec[1] = v1; in_vec[2] = v2; in_vec[3] = v3;
    endtask

    task automatic load_vec();
        int n;
        for (int i = 0; i < IN_LEN; i++) begin
            in_valid = 1'b1;
            in_data  = in_vec[i];
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clock); #1;
                n++;
            end
            if (!in_ready) begin
                checks++; fails++;
                $display("FAIL load_timeout beat %0d: in_ready got 0 expected 1", i);
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int n);
        int cyc;
        out_ready = 1'b1;
        lat = -1;
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            while (!out_valid && cyc < 100) begin
                @(posedge clock); #1;
                cyc++;
            end
            if (!out_valid) begin
                checks++; fails++;
                $display("FAIL collect_timeout output %0d: out_valid got 0 expected 1", k);
                res[k] = 'x;
            end else begin
                if (k == 0) lat = cyc;
                res[k] = out_data;
                @(posedge clock); #1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin fails++; $display("FAIL rst_out_data got %0d expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b expected 0", busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rel_in_ready got %b expected 1", in_ready); end
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        logic signed [FW-1:0] e [4] = '{16'sd2560, 16'sd2570, 16'sd2580, 16'sd2530};
        set_cfg(16'sd256, 16'sd0, 16'sd10, 16'sd20, -16'sd30);
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        relu_en = 1'b1;
        load_vec();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy got %b expected 1", busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_in_ready got %b expected 0", in_ready); end
        collect(4);
        checks++; if (lat !== 5) begin fails++; $display("FAIL basic_latency got %0d expected 5", lat); end
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== e[o]) begin fails++; $display("FAIL basic_out%0d got %0d expected %0d", o, res[o], e[o]); end
        end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_idle got %b expected 0", busy); end
    endtask

    task automatic test_relu_neg();
        set_cfg(-16'sd256, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        relu_en = 1'b1;
        load_vec();
        collect(4);
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== 16'sd0) begin fails++; $display("FAIL relu_out%0d got %0d expected 0", o, res[o]); end
        end
        relu_en = 1'b0;
        load_vec();
        collect(4);
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== -16'sd2560) begin fails++; $display("FAIL neg_out%0d got %0d expected -2560", o, res[o]); end
        end
    endtask

    task automatic test_saturation();
        set_cfg(16'sd32767, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        set_vec(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
        relu_en = 1'b1;
        load_vec();
        collect(4);
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== 16'sd32767) begin fails++; $display("FAIL sat_hi_out%0d got %0d expected 32767", o, res[o]); end
        end
        set_cfg(-16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        relu_en = 1'b0;
        load_vec();
        collect(4);
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== -16'sd32768) begin fails++; $display("FAIL sat_lo_out%0d got %0d expected -32768", o, res[o]); end
        end
    endtask

    task automatic test_backpressure();
        logic signed [FW-1:0] e [3] = '{16'sd2570, 16'sd2580, 16'sd2530};
        int n;
        set_cfg(16'sd256, 16'sd0, 16'sd10, 16'sd20, -16'sd30);
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        relu_en = 1'b1;
        load_vec();
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        checks++; if (out_data !== 16'sd2560) begin fails++; $display("FAIL bp_out0 got %0d expected 2560", out_data); end
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid cyc%0d got %b expected 1", c, out_valid); end
            checks++; if (out_data !== 16'sd2570) begin fails++; $display("FAIL bp_data cyc%0d got %0d expected 2570", c, out_data); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc%0d got %b expected 0", c, in_ready); end
            @(posedge clock); #1;
        end
        collect(3);
        for (int o = 0; o < 3; o++) begin
            checks++;
            if (res[o] !== e[o]) begin fails++; $display("FAIL bp_out%0d got %0d expected %0d", o + 1, res[o], e[o]); end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [FW-1:0] e [4] = '{16'sd2560, 16'sd2570, 16'sd2580, 16'sd2530};
        in_valid = 1'b1;
        in_data  = 16'sd999;
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b expected 1", in_ready); end
        @(posedge clock); #1;
        set_vec(16'sd256, 16'sd512, 16'sd768, 16'sd1024);
        load_vec();
        collect(4);
        for (int o = 0; o < 4; o++) begin
            checks++;
            if (res[o] !== e[o]) begin fails++; $display("FAIL midrst_out%0d got %0d expected %0d", o, res[o], e[o]); end
        end
    endtask

    task automatic test_busy_write();
        load_vec();
        wgt_we   = 1'b1;
        wgt_addr = 4'd0;
        wgt_data = 16'sd0;
        @(posedge clock); #1;
        wgt_we = 1'b0;
        collect(4);
        checks++; if (res[0] !== 16'sd2560) begin fails++; $display("FAIL busywr_out0 got %0d expected 2560", res[0]); end
        load_vec();
        collect(4);
        checks++; if (res[0] !== 16'sd2560) begin fails++; $display("FAIL busywr_next_out0 got %0d expected 2560", res[0]); end
        wgt_we   = 1'b1;
        wgt_addr = 4'd0;
        wgt_data = 16'sd0;
        @(posedge clock); #1;
        wgt_we = 1'b0;
        load_vec();
        collect(4);
        checks++; if (res[0] !== 16'sd2304) begin fails++; $display("FAIL idlewr_out0 got %0d expected 2304", res[0]); end
        checks++; if (res[1] !== 16'sd2570) begin fails++; $display("FAIL idlewr_out1 got %0d expected 2570", res[1]); end
    endtask

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        relu_en   = 1'b1;
        wgt_we    = 1'b0;
        wgt_addr  = '0;
        wgt_data  = '0;
        bias_we   = 1'b0;
        bias_addr = '0;
        bias_data = '0;
        test_reset();
        test_basic();
        test_relu_neg();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_busy_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dense_lanes.md
Name: dense_lanes

Overview:
- Next-generation fully-connected layer for the MNIST inference pipeline.
- Computes out[o] = act(bias[o] + sum_i((in[i]*w[o][i]) >>> FRAC_BITS)) with LANES output neurons evaluated in parallel.
- Weights and biases are loaded at runtime through a write port instead of from files.
- Runtime ReLU enable and output saturation.
- Sits between feature-stream stages using valid/ready handshakes, one feature per beat.

Parameters:
- IN_LEN, 784, input vector length.
- OUT_LEN, 100, output vector length; must be a multiple of LANES (elaboration $error otherwise).
- LANES, 4, parallel MAC units, i.e. outputs computed per group.
- FEATURE_W, 16, signed feature width.
- WEIGHT_W, 16, signed weight/bias width.
- FRAC_BITS, 8, fractional bits of features and weights.
- ACC_W, 40, signed accumulator width.

Ports:
- clock  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input feature valid.
- in_ready  out  1  block accepts an input feature.
- in_data  in  FEATURE_W  signed input feature.
- out_valid  out  1  output feature valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  FEATURE_W  signed output feature.
- relu_en  in  1  1 = clamp negatives to 0; sampled in FINAL.
- wgt_we  in  1  weight write strobe.
- wgt_addr  in  clog2(IN_LEN*OUT_LEN)  weight address = o*IN_LEN+i.
- wgt_data  in  WEIGHT_W  weight value.
- bias_we  in  1  bias write strobe.
- bias_addr  in  clog2(OUT_LEN)  bias index.
- bias_data  in  WEIGHT_W  bias value, added unshifted at feature scale.
- busy  out  1  high in every state except LOAD.

Behaviour:
- Reset (reset_n=1, async): state=LOAD; input index, group and lane counters=0; in_ready=0 while reset is held, 1 on the first cycle after release; out_valid=0; out_data=0; busy=0. Weight, bias and input buffers are not cleared.
- LOAD:
  - in_ready=1; each handshake stores in_data into the input buffer at index i, then i++.
  - The handshake with i=IN_LEN-1 moves to COMPUTE with group g=0.
- COMPUTE:
  - Exactly IN_LEN cycles; cycle k performs acc[l] += sext((in[k]*w[g*LANES+l][k]) >>> FRAC_BITS) for l=0..LANES-1.
  - Product is FEATURE_W+WEIGHT_W bits, arithmetic shift, sign-extended to ACC_W.
  - Accumulators are cleared on entry.
- FINAL (1 cycle):
  - r[l] = acc[l] + sext(bias[g*LANES+l]).
  - Saturate to [-2^(FEATURE_W-1), 2^(FEATURE_W-1)-1].
  - If relu_en and r<0, r=0.
  - Results go to the output bank; go to EMIT with lane=0.
- EMIT:
  - out_valid=1, out_data=bank[lane].
  - Data is held stable until the out_valid&out_ready handshake.
  - On handshake: lane++. After lane LANES-1: if g<OUT_LEN/LANES-1 then g++ and go to COMPUTE; else go to LOAD with i=0.
- Latency: out_valid rises IN_LEN+1 cycles after the edge accepting the last input. Each later group adds IN_LEN+1 cycles after the previous group's last output handshake.
- Output order: o=0..OUT_LEN-1 strictly.
- Throughput: no overlap. The next input vector is accepted only after the final output handshake.
- in_valid while in_ready=0 is ignored; inputs are never dropped or duplicated.
- wgt_we/bias_we take effect only when busy=0. Writes while busy=1 are discarded.
- Simultaneous wgt_we and bias_we are both performed.
- Reset mid-operation: aborts immediately; partial input/accumulators are discarded; loaded weights and biases are kept.
- ACC_W must be sized so the accumulation never wraps. Only the final result saturates.

Test Plan:
- Config IN_LEN=4, OUT_LEN=4, LANES=2, FRAC_BITS=8; all w=256; bias={0,10,20,-30}; in={256,512,768,1024}; relu_en=1 -> outputs 2560, 2570, 2580, 2530 in order; first out_valid 5 cycles after last input.
- Same setup with all w=-256, bias=0 -> relu_en=1 gives 0,0,0,0; relu_en=0 gives -2560 x4.
- Saturation: in=32767 x4, w=32767 -> 32767 x4; with w=-32768, relu_en=0 -> -32768 x4.
- Backpressure: out_ready=0 for 5 cycles while output 1 is valid -> out_valid stays 1, out_data stable at 2570, no loss; in_ready=0 throughout.
- Reset after 2 inputs accepted -> out_valid=0, in_ready=1 after release; a full vector then reproduces the scenario 1 outputs using the retained weights.
- wgt_we with addr 0, data 0 while busy -> ignored, outputs unchanged. The same write while idle -> output 0 becomes 2560-256=2304.
